// File: rtl/fabosc_clk_en_sched_if.sv
//------------------------------------------------------------------------------
// Module   : fabosc_clk_en_sched_if
// Brief    : Config, request/grant and clock-enable bundle for the oscillator scheduler.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fabosc_clk_en_sched_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              CFG_WE;
  logic [SEL_W-1:0]  CFG_SEL;
  logic [DIV_W-1:0]  CFG_WDATA;
  logic              CFG_ACK;
  logic [NUM_CH-1:0] REQ;
  logic [NUM_CH-1:0] GNT;
  logic [NUM_CH-1:0] CE;
  logic              READY;
  logic [NUM_CH-1:0] TIMEOUT;

  modport master (
    output CFG_WE, CFG_SEL, CFG_WDATA, REQ,
    input  CFG_ACK, GNT, CE, READY, TIMEOUT
  );

  modport slave (
    input  CFG_WE, CFG_SEL, CFG_WDATA, REQ,
    output CFG_ACK, GNT, CE, READY, TIMEOUT
  );
endinterface

`default_nettype wire

// File: rtl/fabosc_clk_en_sched.sv
//------------------------------------------------------------------------------
// Module   : fabosc_clk_en_sched
// Brief    : Settle sequencer, round-robin grant of the fabric oscillator and
//            per-channel divided clock-enable strobes. Optional hold limit under
//            macro FABOSC_SCHED_TIMEOUT_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fabosc_clk_en_sched #(
  parameter int NUM_CH        = 4,
  parameter int DIV_W         = 16,
  parameter int MAX_GNT       = 2,
  parameter int SETTLE_CYCLES = 1024,
  parameter int HOLD_MAX      = 256
) (
  input  logic                  CLK,
  input  logic                  RESET,
  fabosc_clk_en_sched_if.slave  bus
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_SETTLE = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [NUM_CH-1:0] ce_q, ce_d;
  logic              ack_q, ack_d;
  logic [DIV_W-1:0]  div_q    [NUM_CH];
  logic [DIV_W-1:0]  div_d    [NUM_CH];
  logic [DIV_W-1:0]  shadow_q [NUM_CH];
  logic [DIV_W-1:0]  shadow_d [NUM_CH];
  logic [DIV_W-1:0]  cnt_q    [NUM_CH];
  logic [DIV_W-1:0]  cnt_d    [NUM_CH];

  logic              wr_ok;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] new_gnt;
  logic [NUM_CH-1:0] force_rel;
  logic [NUM_CH-1:0] blocked;
  logic [SEL_W-1:0]  scan_idx;
  logic [SEL_W-1:0]  pick;
  logic              found;
  int                gcnt;

  assign wr_ok   = bus.CFG_WE && (int'(bus.CFG_SEL) < NUM_CH);
  assign pending = bus.REQ & ~gnt_q & ~blocked;

  // div_d doubles as the forwarded divider, so a write in the wrap/grant cycle wins.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    ptr_d    = ptr_q;
    ack_d    = wr_ok;
    gnt_d    = '0;
    ce_d     = '0;
    new_gnt  = '0;
    div_d    = div_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    gcnt     = 0;
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;

    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_ok && (bus.CFG_SEL == SEL_W'(i))) begin
        div_d[i] = bus.CFG_WDATA;
      end
    end

    if (state_q == ST_SETTLE) begin
      settle_d = settle_q + 1'b1;
      if (settle_q == SETTLE_LAST) begin
        state_d = ST_RUN;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        gcnt = gcnt + int'(gnt_q[i]);
      end
      // Slots freed this cycle still count, so a release never feeds a same-cycle grant.
      if (gcnt < MAX_GNT) begin
        for (int k = 0; k < NUM_CH; k++) begin
          scan_idx = SEL_W'((int'(ptr_q) + k) % NUM_CH);
          if (!found && pending[scan_idx]) begin
            found = 1'b1;
            pick  = scan_idx;
          end
        end
      end
      if (found) begin
        new_gnt[pick] = 1'b1;
        ptr_d         = SEL_W'((int'(pick) + 1) % NUM_CH);
      end
      gnt_d = (gnt_q & bus.REQ & ~force_rel) | new_gnt;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (new_gnt[i]) begin
        cnt_d[i]    = '0;
        shadow_d[i] = div_d[i];
      end else if (gnt_q[i]) begin
        if (cnt_q[i] == shadow_q[i]) begin
          cnt_d[i]    = '0;
          shadow_d[i] = div_d[i];
          ce_d[i]     = gnt_d[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_SETTLE;
      settle_q <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      ce_q     <= '0;
      ack_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]    <= '0;
        shadow_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      ce_q     <= ce_d;
      ack_q    <= ack_d;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]    <= div_d[i];
        shadow_q[i] <= shadow_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

`ifdef FABOSC_SCHED_TIMEOUT_EN
  localparam int HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  logic [HOLD_W-1:0] hold_q [NUM_CH];
  logic [HOLD_W-1:0] hold_d [NUM_CH];
  logic [NUM_CH-1:0] blocked_q, blocked_d;
  logic [NUM_CH-1:0] tmo_q, tmo_d;

  // A forced-off channel stays blocked until its request has been seen low.
  always_comb begin
    force_rel = '0;
    hold_d    = hold_q;
    for (int i = 0; i < NUM_CH; i++) begin
      force_rel[i] = ce_q[i] && gnt_q[i] && (hold_q[i] == HOLD_LAST);
      if (!gnt_q[i] || force_rel[i]) begin
        hold_d[i] = '0;
      end else if (ce_q[i]) begin
        hold_d[i] = hold_q[i] + 1'b1;
      end
    end
    blocked_d = force_rel | (blocked_q & bus.REQ);
    tmo_d     = tmo_q | force_rel;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      blocked_q <= '0;
      tmo_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      blocked_q <= blocked_d;
      tmo_q     <= tmo_d;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign blocked     = blocked_q;
  assign bus.TIMEOUT = tmo_q;
`else
  assign force_rel   = '0;
  assign blocked     = '0;
  assign bus.TIMEOUT = '0;
`endif

  assign bus.GNT     = gnt_q;
  assign bus.CE      = ce_q;
  assign bus.CFG_ACK = ack_q;
  assign bus.READY   = (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_fabosc_clk_en_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_fabosc_clk_en_sched
// Brief    : Directed bench for the oscillator clock-enable scheduler.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fabosc_clk_en_sched;

  logic clk;
  logic rst;
  int   n_tot;
  int   n_bad;

  fabosc_clk_en_sched_if #(.NUM_CH(4), .DIV_W(16)) bus ();

  fabosc_clk_en_sched #(
    .NUM_CH(4), .DIV_W(16), .MAX_GNT(2), .SETTLE_CYCLES(1024), .HOLD_MAX(256)
  ) u_dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [15:0] data);
    bus.CFG_WE    = 1'b1;
    bus.CFG_SEL   = sel;
    bus.CFG_WDATA = data;
    tick();
    bus.CFG_WE = 1'b0;
    check("cfg_ack_hi", 32'(bus.CFG_ACK), 32'd1);
    tick();
    check("cfg_ack_lo", 32'(bus.CFG_ACK), 32'd0);
  endtask

  logic [3:0]  gnt_log [0:1030];
  logic [3:0]  ce_log  [0:1030];
  logic [3:0]  any_pre;
  int          ready_cyc;
  int          c;
  int          ce_cnt;
  logic [12:0] ce1_mask;
  logic [14:0] ce2_mask;

  initial begin
    n_tot         = 0;
    n_bad         = 0;
    rst           = 1'b1;
    bus.REQ       = 4'b1111;
    bus.CFG_WE    = 1'b0;
    bus.CFG_SEL   = '0;
    bus.CFG_WDATA = '0;

    // Reset state, then settle with all channels requesting
    tick();
    check("rst_gnt", 32'(bus.GNT), 32'd0);
    check("rst_ce", 32'(bus.CE), 32'd0);
    check("rst_ready", 32'(bus.READY), 32'd0);
    check("rst_ack", 32'(bus.CFG_ACK), 32'd0);
    check("rst_timeout", 32'(bus.TIMEOUT), 32'd0);
    rst       = 1'b0;
    any_pre   = '0;
    ready_cyc = 0;
    for (int k = 1; k <= 1030; k++) begin
      tick();
      if (bus.READY && ready_cyc == 0) ready_cyc = k;
      if (!bus.READY) any_pre = any_pre | bus.GNT | bus.CE;
      gnt_log[k] = bus.GNT;
      ce_log[k]  = bus.CE;
    end
    check("ready_cycle", 32'(ready_cyc), 32'd1024);
    check("settle_quiet", 32'(any_pre), 32'd0);
    check("gnt_at_ready", 32'(gnt_log[1024]), 32'd0);
    check("gnt_first", 32'(gnt_log[1025]), 32'b0001);
    check("gnt_second", 32'(gnt_log[1026]), 32'b0011);
    check("gnt_cap", 32'(gnt_log[1030]), 32'b0011);
    check("ce_first", 32'(ce_log[1026]), 32'b0001);
    check("ce_both", 32'(ce_log[1027]), 32'b0011);

    // Release ch0; freed slot goes to ch2 one cycle later
    bus.REQ = 4'b1110;
    tick();
    check("rel_gnt", 32'(bus.GNT), 32'b0010);
    check("rel_ce", 32'(bus.CE), 32'b0010);
    tick();
    check("regrant_ch2", 32'(bus.GNT), 32'b0110);

    // Reset while two channels granted
    rst = 1'b1;
    tick();
    check("midrst_gnt", 32'(bus.GNT), 32'd0);
    check("midrst_ce", 32'(bus.CE), 32'd0);
    check("midrst_ready", 32'(bus.READY), 32'd0);
    rst     = 1'b0;
    bus.REQ = 4'b0000;
    cfg_write(2'd1, 16'd3);
    cfg_write(2'd2, 16'd9);
    c = 4;
    while (!bus.READY && c < 3000) begin
      tick();
      c++;
    end
    check("resettle_cycle", 32'(c), 32'd1024);

    // Channel 1 alone with divider 3
    bus.REQ = 4'b0010;
    tick();
    check("ch1_gnt", 32'(bus.GNT), 32'b0010);
    ce1_mask = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      ce1_mask[k] = bus.CE[1];
    end
    check("ch1_ce_pattern", 32'(ce1_mask), 32'h1110);

    // Channel 2 at divider 9, rewritten to 0 mid-period
    bus.REQ = 4'b0110;
    tick();
    check("ch2_gnt", 32'(bus.GNT), 32'b0110);
    ce2_mask = '0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      ce2_mask[k] = bus.CE[2];
      if (k == 3) check("rewrite_ack", 32'(bus.CFG_ACK), 32'd1);
      bus.CFG_WE    = (k == 2);
      bus.CFG_SEL   = 2'd2;
      bus.CFG_WDATA = 16'd0;
    end
    check("ch2_ce_pattern", 32'(ce2_mask), 32'h7C00);

    bus.REQ = 4'b0000;
    tick();
    check("drop_all_gnt", 32'(bus.GNT), 32'd0);
    check("drop_all_ce", 32'(bus.CE), 32'd0);

    // Hold behaviour on channel 3 with divider 0
    cfg_write(2'd3, 16'd0);
    bus.REQ = 4'b1000;
    tick();
    check("ch3_gnt", 32'(bus.GNT), 32'b1000);
`ifdef FABOSC_SCHED_TIMEOUT_EN
    ce_cnt = 0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      ce_cnt += int'(bus.CE[3]);
    end
    check("hold_ce_count", 32'(ce_cnt), 32'd256);
    check("hold_gnt_last", 32'(bus.GNT), 32'b1000);
    tick();
    check("tmo_gnt_drop", 32'(bus.GNT), 32'd0);
    check("tmo_ce_drop", 32'(bus.CE), 32'd0);
    check("tmo_flag", 32'(bus.TIMEOUT), 32'b1000);
    repeat (5) tick();
    check("tmo_no_regrant", 32'(bus.GNT), 32'd0);
    bus.REQ = 4'b0000;
    tick();
    bus.REQ = 4'b1000;
    tick();
    check("tmo_regrant", 32'(bus.GNT), 32'b1000);
    check("tmo_sticky", 32'(bus.TIMEOUT), 32'b1000);
`else
    ce_cnt = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      ce_cnt += int'(bus.CE[3]);
    end
    check("hold_ce_count", 32'(ce_cnt), 32'd300);
    check("hold_gnt_kept", 32'(bus.GNT), 32'b1000);
    check("timeout_tied", 32'(bus.TIMEOUT), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
